// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - Debounced one-hot button play detector for the memory game datapath
module detector_jogada #(
    parameter int N_BOTOES = 4,
    parameter int DEBOUNCE = 4,
    parameter int CW       = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] jogada,
    output logic                tem_jogada,
    output logic                jogada_multipla,
    output logic [2:0]          db_estado
);

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        FILTRA_PRESS  = 3'd1,
        EMITE         = 3'd2,
        ESPERA_SOLTAR = 3'd3,
        FILTRA_SOLTA  = 3'd4
    } estado_t;

    estado_t             estado, estado_nxt;
    logic [N_BOTOES-1:0] botoes_r;
    logic [N_BOTOES-1:0] amostra, amostra_nxt;
    logic [N_BOTOES-1:0] jogada_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic                multipla_nxt;
    logic                cnt_fim;

    function automatic int popcount(input logic [N_BOTOES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < N_BOTOES; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    assign cnt_fim = (cnt == CW'(DEBOUNCE - 2));

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado          <= ESPERA_SOLTAR;
            botoes_r        <= '0;
            amostra         <= '0;
            cnt             <= '0;
            jogada          <= '0;
            jogada_multipla <= 1'b0;
        end else begin
            estado          <= estado_nxt;
            botoes_r        <= botoes;
            amostra         <= amostra_nxt;
            cnt             <= cnt_nxt;
            jogada          <= jogada_nxt;
            jogada_multipla <= multipla_nxt;
        end
    end

    always_comb begin
        estado_nxt   = estado;
        amostra_nxt  = amostra;
        cnt_nxt      = cnt;
        jogada_nxt   = jogada;
        multipla_nxt = 1'b0;
        case (estado)
            OCIOSO: begin
                if (botoes_r != '0) begin
                    if (enable) begin
                        estado_nxt  = FILTRA_PRESS;
                        amostra_nxt = botoes_r;
                        cnt_nxt     = '0;
                    end else begin
                        // a press begun while disabled must be released before it can count
                        estado_nxt = ESPERA_SOLTAR;
                    end
                end
            end
            FILTRA_PRESS: begin
                if (!enable) begin
                    estado_nxt = ESPERA_SOLTAR;
                end else if (botoes_r != amostra) begin
                    estado_nxt = OCIOSO;
                end else if (cnt_fim) begin
                    if (popcount(amostra) == 1) begin
                        estado_nxt = EMITE;
                        jogada_nxt = amostra;
                    end else begin
                        estado_nxt   = ESPERA_SOLTAR;
                        multipla_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            EMITE: begin
                estado_nxt = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                if (botoes_r == '0) begin
                    estado_nxt = FILTRA_SOLTA;
                    cnt_nxt    = '0;
                end
            end
            FILTRA_SOLTA: begin
                if (botoes_r != '0) begin
                    estado_nxt = ESPERA_SOLTAR;
                end else if (cnt_fim) begin
                    estado_nxt = OCIOSO;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                estado_nxt = ESPERA_SOLTAR;
            end
        endcase
    end

    assign tem_jogada = (estado == EMITE);
    assign db_estado  = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// tb/tb_detector_jogada.sv - Directed self-checking bench for detector_jogada
module tb_detector_jogada;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] botoes;
    logic [3:0] jogada;
    logic       tem_jogada;
    logic       jogada_multipla;
    logic [2:0] db_estado;

    int compared;
    int mismatched;
    int pulses;
    int mults;
    int overlaps;
    int first_pulse;
    logic [3:0] jogada_no_pulso;

    detector_jogada #(.N_BOTOES(4), .DEBOUNCE(4), .CW(3)) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .botoes          (botoes),
        .jogada          (jogada),
        .tem_jogada      (tem_jogada),
        .jogada_multipla (jogada_multipla),
        .db_estado       (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_counts();
        pulses          = 0;
        mults           = 0;
        first_pulse     = -1;
        jogada_no_pulso = 'x;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (tem_jogada === 1'b1) begin
                if (pulses == 0) first_pulse = i;
                pulses++;
                jogada_no_pulso = jogada;
            end
            if (jogada_multipla === 1'b1) mults++;
            if (tem_jogada === 1'b1 && jogada_multipla === 1'b1) overlaps++;
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        overlaps   = 0;
        reset      = 1'b0;
        enable     = 1'b0;
        botoes     = 4'b0000;
        clear_counts();

        // 1: reset lands in ESPERA_SOLTAR, idles into OCIOSO after 4 zero samples
        tick(2);
        check("rst_jogada", 32'(jogada), 32'h0);
        check("rst_tem", 32'(tem_jogada), 32'h0);
        check("rst_estado", 32'(db_estado), 32'd3);
        reset = 1'b1;
        tick(3);
        check("idle_estado_3", 32'(db_estado), 32'd4);
        tick(1);
        check("idle_estado_4", 32'(db_estado), 32'd0);

        // 2: clean press, latency of DEBOUNCE edges after the first sample
        enable = 1'b1;
        botoes = 4'b0100;
        clear_counts();
        tick(10);
        check("p2_pulses", 32'(pulses), 32'd1);
        check("p2_latency", 32'(first_pulse), 32'd4);
        check("p2_jogada_pulso", 32'(jogada_no_pulso), 32'h4);
        botoes = 4'b0000;
        tick(8);
        check("p2_jogada_held", 32'(jogada), 32'h4);
        check("p2_pulses_total", 32'(pulses), 32'd1);
        check("p2_estado", 32'(db_estado), 32'd0);

        // 3: bouncing press then stable
        clear_counts();
        for (int k = 0; k < 6; k++) begin
            botoes = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            tick(1);
        end
        check("p3_bounce_pulses", 32'(pulses), 32'd0);
        botoes = 4'b0010;
        tick(10);
        check("p3_pulses", 32'(pulses), 32'd1);
        check("p3_jogada", 32'(jogada), 32'h2);
        botoes = 4'b0000;
        tick(8);

        // 4: two buttons at once are rejected
        clear_counts();
        botoes = 4'b0011;
        tick(10);
        check("p4_mult", 32'(mults), 32'd1);
        check("p4_tem", 32'(pulses), 32'd0);
        check("p4_jogada", 32'(jogada), 32'h2);
        botoes = 4'b0000;
        tick(8);

        // 5: press while disabled, then enable while held, then re-arm boundary
        clear_counts();
        enable = 1'b0;
        botoes = 4'b1000;
        tick(5);
        check("p5_disabled", 32'(pulses), 32'd0);
        enable = 1'b1;
        tick(6);
        check("p5_enabled_held", 32'(pulses), 32'd0);
        botoes = 4'b0000;
        tick(3);
        botoes = 4'b1000;
        tick(8);
        check("p5_three_zeros", 32'(pulses), 32'd0);
        botoes = 4'b0000;
        tick(4);
        botoes = 4'b1000;
        tick(10);
        check("p5_four_zeros", 32'(pulses), 32'd1);
        check("p5_jogada", 32'(jogada), 32'h8);
        botoes = 4'b0000;
        tick(8);

        // 6: reset mid-press, button held across reset release
        clear_counts();
        botoes = 4'b0001;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("p6_rst_estado", 32'(db_estado), 32'd3);
        check("p6_rst_jogada", 32'(jogada), 32'h0);
        reset = 1'b1;
        tick(10);
        check("p6_held", 32'(pulses), 32'd0);
        botoes = 4'b0000;
        tick(8);
        botoes = 4'b0001;
        tick(10);
        check("p6_pulses", 32'(pulses), 32'd1);
        check("p6_jogada", 32'(jogada), 32'h1);
        botoes = 4'b0000;
        tick(4);

        check("overlap", 32'(overlaps), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
